// File: rtl/data_cache.sv
// ============================================================================
// Module   : data_cache
// Brief    : 8-line x 4-byte direct-mapped, write-back, write-allocate cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITE_DATA,
    output logic [7:0]  READ_DATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        entry_q;
    logic [7:0]  valid_q, dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];
    logic [7:0]  rdata_q;

    logic [2:0]  w_tag, w_index;
    logic [1:0]  w_offset;
    logic        w_req, w_hit, w_done;
    logic [31:0] w_line;
    logic [7:0]  w_byte;

    assign w_tag    = ADDRESS[7:5];
    assign w_index  = ADDRESS[4:2];
    assign w_offset = ADDRESS[1:0];
    assign w_req    = READ | WRITE;
    assign w_hit    = valid_q[w_index] && (tag_q[w_index] == w_tag);
    assign w_line   = data_q[w_index];
    assign w_byte   = w_line[{w_offset, 3'b000} +: 8];
    // The entry cycle of a memory state never completes, giving a 2-cycle minimum.
    assign w_done   = !entry_q && !MEM_BUSYWAIT;

    always_comb begin
        state_d       = state_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'd0;
        MEM_WRITEDATA = 32'd0;
        case (state_q)
            IDLE: begin
                BUSYWAIT = w_req & ~w_hit;
                if (w_req && !w_hit)
                    state_d = (valid_q[w_index] && dirty_q[w_index]) ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[w_index], w_index};
                MEM_WRITEDATA = w_line;
                if (w_done)
                    state_d = FETCH;
            end
            FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {w_tag, w_index};
                if (w_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold the last delivered byte when no read hit is being served.
    assign READ_DATA = (state_q == IDLE && READ && w_hit) ? w_byte : rdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            entry_q <= 1'b0;
            valid_q <= 8'd0;
            dirty_q <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);
            rdata_q <= READ_DATA;
            if (state_q == IDLE && WRITE && w_hit)
                dirty_q[w_index] <= 1'b1;
            if (state_q == WRITEBACK && w_done)
                dirty_q[w_index] <= 1'b0;
            if (state_q == FETCH && w_done) begin
                valid_q[w_index] <= 1'b1;
                dirty_q[w_index] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state_q == IDLE && WRITE && w_hit)
                data_q[w_index][{w_offset, 3'b000} +: 8] <= WRITE_DATA;
            if (state_q == FETCH && w_done) begin
                data_q[w_index] <= MEM_READDATA;
                tag_q[w_index]  <= w_tag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
// ============================================================================
// Module   : tb_data_cache
// Brief    : Directed self-checking bench for data_cache with a latency-programmable memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0, WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'd0, WRITE_DATA = 8'd0;
    logic [7:0]  READ_DATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;

    int n_checks = 0;
    int n_fail = 0;
    int mem_lat = 3;

    logic [31:0] mem [64];
    bit          written [64];
    int          cnt = 0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    int          n_fetch = 0, n_wb = 0, fetch_cycles = 0;
    logic [5:0]  last_fetch_addr = 6'd0, last_wb_addr = 6'd0;
    logic [31:0] last_wb_data = 32'd0;
    bit          overlap = 1'b0;

    data_cache dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_blk(input logic [5:0] a);
        case (a)
            6'h09:   return 32'h44332211;
            6'h29:   return 32'h88776655;
            6'h04:   return 32'hDDCCBBAA;
            6'h07:   return 32'h0F0E0D0C;
            6'h17:   return 32'h11223344;
            default: return {4{2'b00, a}};
        endcase
    endfunction

    assign MEM_READDATA = written[MEM_ADDRESS] ? mem[MEM_ADDRESS] : init_blk(MEM_ADDRESS);
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < mem_lat);

    always @(posedge CLK) begin
        cnt <= ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) ? cnt + 1 : 0;
        prev_rd <= MEM_READ;
        prev_wr <= MEM_WRITE;
        if (MEM_READ && MEM_WRITE) overlap <= 1'b1;
        if (MEM_READ) fetch_cycles <= fetch_cycles + 1;
        if (MEM_READ && !prev_rd) begin
            n_fetch <= n_fetch + 1;
            last_fetch_addr <= MEM_ADDRESS;
        end
        if (MEM_WRITE && !prev_wr) begin
            n_wb <= n_wb + 1;
            last_wb_addr <= MEM_ADDRESS;
            last_wb_data <= MEM_WRITEDATA;
        end
        if (MEM_WRITE && !MEM_BUSYWAIT) begin
            mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            written[MEM_ADDRESS] <= 1'b1;
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wd, output int stall, output logic [7:0] rdata);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITE_DATA = wd;
        stall = 0;
        #1;
        while (BUSYWAIT === 1'b1 && stall <= 40) begin
            @(negedge CLK); #1;
            stall++;
        end
        rdata = READ_DATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic test_reset();
        int f0;
        @(negedge CLK); RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK); RESET = 1'b0;
        #1;
        n_checks++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait got %b exp 0", BUSYWAIT); end
        n_checks++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %b exp 0", MEM_READ); end
        n_checks++; if (MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b exp 0", MEM_WRITE); end
        n_checks++; if (MEM_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL reset_mem_address got %h exp 00", MEM_ADDRESS); end
        n_checks++; if (MEM_WRITEDATA !== 32'h0) begin n_fail++; $display("FAIL reset_mem_writedata got %h exp 0", MEM_WRITEDATA); end
        n_checks++; if (READ_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_read_data got %h exp 00", READ_DATA); end
        f0 = n_fetch + n_wb;
        repeat (3) @(negedge CLK);
        #1;
        n_checks++; if ((MEM_READ | MEM_WRITE) !== 1'b0 || n_fetch + n_wb != f0)
            begin n_fail++; $display("FAIL idle_traffic got rd=%b wr=%b exp no traffic", MEM_READ, MEM_WRITE); end
    endtask

    task automatic test_read_miss();
        int st, f0; logic [7:0] d;
        mem_lat = 3;
        f0 = n_fetch;
        do_access(1'b1, 1'b0, 8'h25, 8'h00, st, d);
        n_checks++; if (st != 5) begin n_fail++; $display("FAIL read_miss_stall got %0d exp 5", st); end
        n_checks++; if (d !== 8'h22) begin n_fail++; $display("FAIL read_miss_data got %h exp 22", d); end
        n_checks++; if (n_fetch - f0 != 1) begin n_fail++; $display("FAIL read_miss_fetches got %0d exp 1", n_fetch - f0); end
        n_checks++; if (last_fetch_addr !== 6'h09) begin n_fail++; $display("FAIL read_miss_addr got %h exp 09", last_fetch_addr); end
        do_access(1'b1, 1'b0, 8'h24, 8'h00, st, d);
        n_checks++; if (st != 0) begin n_fail++; $display("FAIL read_hit_stall got %0d exp 0", st); end
        n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL read_hit_data got %h exp 11", d); end
    endtask

    task automatic test_write_hit();
        int st; logic [7:0] d;
        do_access(1'b0, 1'b1, 8'h26, 8'hAB, st, d);
        n_checks++; if (st != 0) begin n_fail++; $display("FAIL write_hit_stall got %0d exp 0", st); end
        do_access(1'b1, 1'b0, 8'h26, 8'h00, st, d);
        n_checks++; if (st != 0) begin n_fail++; $display("FAIL write_hit_rd_stall got %0d exp 0", st); end
        n_checks++; if (d !== 8'hAB) begin n_fail++; $display("FAIL write_hit_rd_data got %h exp ab", d); end
    endtask

    task automatic test_dirty_evict();
        int st, w0; logic [7:0] d;
        w0 = n_wb;
        do_access(1'b1, 1'b0, 8'hA5, 8'h00, st, d);
        n_checks++; if (st != 9) begin n_fail++; $display("FAIL evict_stall got %0d exp 9", st); end
        n_checks++; if (n_wb - w0 != 1) begin n_fail++; $display("FAIL evict_wb_count got %0d exp 1", n_wb - w0); end
        n_checks++; if (last_wb_addr !== 6'h09) begin n_fail++; $display("FAIL evict_wb_addr got %h exp 09", last_wb_addr); end
        n_checks++; if (last_wb_data !== 32'h44AB2211) begin n_fail++; $display("FAIL evict_wb_data got %h exp 44ab2211", last_wb_data); end
        n_checks++; if (last_fetch_addr !== 6'h29) begin n_fail++; $display("FAIL evict_fetch_addr got %h exp 29", last_fetch_addr); end
        n_checks++; if (d !== 8'h66) begin n_fail++; $display("FAIL evict_data got %h exp 66", d); end
    endtask

    task automatic test_write_miss();
        int st; logic [7:0] d;
        do_access(1'b0, 1'b1, 8'h10, 8'h5A, st, d);
        n_checks++; if (st != 5) begin n_fail++; $display("FAIL write_miss_stall got %0d exp 5", st); end
        do_access(1'b1, 1'b0, 8'h10, 8'h00, st, d);
        n_checks++; if (st != 0 || d !== 8'h5A) begin n_fail++; $display("FAIL write_miss_rd0 got st=%0d d=%h exp st=0 d=5a", st, d); end
        do_access(1'b1, 1'b0, 8'h11, 8'h00, st, d);
        n_checks++; if (st != 0 || d !== 8'hBB) begin n_fail++; $display("FAIL write_miss_rd1 got st=%0d d=%h exp st=0 d=bb", st, d); end
        do_access(1'b1, 1'b0, 8'h90, 8'h00, st, d);
        n_checks++; if (st != 9) begin n_fail++; $display("FAIL write_miss_dirty_stall got %0d exp 9", st); end
        n_checks++; if (last_wb_addr !== 6'h04 || last_wb_data !== 32'hDDCCBB5A)
            begin n_fail++; $display("FAIL write_miss_wb got %h/%h exp 04/ddccbb5a", last_wb_addr, last_wb_data); end
        n_checks++; if (d !== 8'h24) begin n_fail++; $display("FAIL write_miss_refill_data got %h exp 24", d); end
    endtask

    task automatic test_reset_mid_fetch();
        int st; logic [7:0] d;
        mem_lat = 3;
        @(negedge CLK); READ = 1'b1; ADDRESS = 8'h1C;
        @(negedge CLK);
        @(negedge CLK); #1;
        n_checks++; if (MEM_READ !== 1'b1) begin n_fail++; $display("FAIL midfetch_active got %b exp 1", MEM_READ); end
        RESET = 1'b1;
        @(negedge CLK); #1;
        n_checks++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0)
            begin n_fail++; $display("FAIL midfetch_abort got rd=%b wr=%b exp 0/0", MEM_READ, MEM_WRITE); end
        RESET = 1'b0; READ = 1'b0;
        do_access(1'b1, 1'b0, 8'h1C, 8'h00, st, d);
        n_checks++; if (st != 5) begin n_fail++; $display("FAIL midfetch_remiss_stall got %0d exp 5", st); end
        n_checks++; if (d !== 8'h0C) begin n_fail++; $display("FAIL midfetch_remiss_data got %h exp 0c", d); end
    endtask

    task automatic test_back_to_back();
        int st, c0; logic [7:0] d;
        mem_lat = 0;
        c0 = fetch_cycles;
        do_access(1'b1, 1'b0, 8'h5C, 8'h00, st, d);
        n_checks++; if (st != 3) begin n_fail++; $display("FAIL fast_fetch_stall got %0d exp 3", st); end
        n_checks++; if (fetch_cycles - c0 != 2) begin n_fail++; $display("FAIL fast_fetch_cycles got %0d exp 2", fetch_cycles - c0); end
        n_checks++; if (d !== 8'h44) begin n_fail++; $display("FAIL fast_fetch_data got %h exp 44", d); end
        n_checks++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL rd_wr_overlap got %b exp 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_evict();
        test_write_miss();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters: none; geometry fixed: 8 lines x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 Reset is RESET, synchronous, active-high; clock is CLK.
REQ-003 CLK  in  1  clock, all state updates on rising edge.
REQ-004 RESET  in  1  synchronous active-high reset.
REQ-005 READ  in  1  CPU load request, held until BUSYWAIT low.
REQ-006 WRITE  in  1  CPU store request, held until BUSYWAIT low.
REQ-007 ADDRESS  in  8  CPU byte address: tag [7:5], index [4:2], offset [1:0].
REQ-008 WRITE_DATA  in  8  CPU store byte.
REQ-009 READ_DATA  out  8  CPU load byte.
REQ-010 BUSYWAIT  out  1  CPU stall; CPU holds PC while high.
REQ-011 MEM_READ  out  1  block fetch request to main memory.
REQ-012 MEM_WRITE  out  1  block write-back request to main memory.
REQ-013 MEM_ADDRESS  out  6  block address {tag,index}.
REQ-014 MEM_WRITEDATA  out  32  victim block; byte 0 in [7:0].
REQ-015 MEM_READDATA  in  32  fetched block; byte 0 in [7:0].
REQ-016 MEM_BUSYWAIT  in  1  memory busy; low marks completion.

Function
REQ-017 Per line storage: valid bit, dirty bit, 3-bit tag, 32-bit data.
REQ-018 Hit = valid[index] and tag[index]==ADDRESS[7:5]; combinational.
REQ-019 FSM states IDLE, WRITEBACK, FETCH; reset state IDLE.
REQ-020 IDLE: BUSYWAIT = (READ|WRITE) & ~hit; MEM_READ=MEM_WRITE=0.
REQ-021 Read hit: READ_DATA = byte ADDRESS[1:0] of line, combinational, same cycle; BUSYWAIT low; zero-cycle stall.
REQ-022 Write hit: WRITE_DATA written into byte ADDRESS[1:0] at the rising edge ending the hit cycle; dirty set; BUSYWAIT low.
REQ-023 READ and WRITE both high: treated as write.
REQ-024 Miss, victim clean or invalid: IDLE -> FETCH at next edge.
REQ-025 Miss, victim valid and dirty: IDLE -> WRITEBACK at next edge.
REQ-026 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data, BUSYWAIT=1.
REQ-027 FETCH: MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}, BUSYWAIT=1.
REQ-028 Leave WRITEBACK/FETCH at the first edge with MEM_BUSYWAIT=0, excluding the entry cycle (minimum 2 cycles in state).
REQ-029 WRITEBACK completion -> FETCH; dirty cleared.
REQ-030 FETCH completion: line data=MEM_READDATA, tag updated, valid=1, dirty=0; -> IDLE.
REQ-031 After fill, IDLE re-evaluates: access hits and completes per REQ-021/022 (write sets dirty).
REQ-032 No request in IDLE: no state change, no memory traffic; READ_DATA holds last selected byte value (don't-care to CPU).
REQ-033 Miss latency (clean) = 1 + fetch cycles + 1 hit cycle; dirty adds write-back cycles.
REQ-034 MEM_READ and MEM_WRITE never high simultaneously.
REQ-035 ADDRESS/WRITE_DATA changes while not IDLE: ignored until IDLE (CPU holds them stable).

Reset
REQ-036 RESET at an edge: all valid and dirty bits 0, state IDLE; data and tag arrays need not reset.
REQ-037 Outputs after reset: BUSYWAIT follows REQ-020 (0 with no request), MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READ_DATA=0.
REQ-038 RESET mid-WRITEBACK/FETCH: transaction abandoned, MEM_READ/MEM_WRITE low from the next cycle, no line updated.

Verification
REQ-039 After reset, READ addr 0x25, memory returns 0x44332211 after 3 busy cycles -> one FETCH with MEM_ADDRESS=0x09, then READ_DATA=0x22, BUSYWAIT low; repeat read 0x24 -> 0x11 with no stall.
REQ-040 WRITE 0xAB to 0x26 after REQ-039 fill -> no stall; subsequent read 0x26 -> 0xAB; line dirty.
REQ-041 READ 0xA5 (same index 1, tag 5) after REQ-040 -> WRITEBACK with MEM_ADDRESS=0x09, MEM_WRITEDATA=0x44AB2211, then FETCH with MEM_ADDRESS=0x29.
REQ-042 WRITE miss to 0x10 clean line -> FETCH, fill, byte written, dirty=1, BUSYWAIT released after hit cycle.
REQ-043 RESET asserted during FETCH -> MEM_READ low next cycle; subsequent read of same address misses again.
REQ-044 MEM_BUSYWAIT held low throughout FETCH -> FETCH lasts exactly 2 cycles; MEM_READ/MEM_WRITE never overlap.
